// File: rtl/clk_period_monitor.sv
// Slow-clock period monitor: synchronizes clk_in, emits ticks, measures periods, flags range/loss.
// Optional high-time measurement and check enabled by defining CLK_PERIOD_MONITOR_DUTY_EN.
module clk_period_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned NOM_PERIOD  = 50002,
  parameter int unsigned TOL         = 250,
  parameter int unsigned TIMEOUT     = 100000
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             enable,
  input  logic             clk_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             lost,
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic [7:0]       err_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W:0]   NOM_C     = (CNT_W+1)'(NOM_PERIOD);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOST} state_e;

  state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             in_range_q, in_range_d;
  logic             lost_q, lost_d;
  logic [7:0]       err_q, err_d;
  logic             tick_q;
  logic             sync_out_c, rise_c, fall_c;
  logic             per_ok_c, duty_ok_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [7:0]       err_inc_c;

  // |val - nom| <= TOL using a one-bit-wider signed difference
  function automatic logic within_tol(input logic [CNT_W-1:0] val, input logic [CNT_W:0] nom);
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]        mag;
    diff = $signed({1'b0, val}) - $signed(nom);
    mag  = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    return (mag <= TOL_C);
  endfunction

  assign sync_out_c = sync_q[SYNC_STAGES-1];
  assign rise_c     = sync_out_c & ~prev_q;
  assign fall_c     = ~sync_out_c & prev_q;
  assign per_ok_c   = within_tol(cnt_q, NOM_C);
  assign cnt_inc_c  = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + ONE_C;
  assign err_inc_c  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  // Synchronizer, edge-detect and tick
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      prev_q <= sync_out_c;
      tick_q <= rise_c & enable;
    end
  end

  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      lost_q         <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      in_range_q     <= in_range_d;
      lost_q         <= lost_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    in_range_d     = in_range_q;
    lost_d         = lost_q;
    err_d          = err_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (rise_c) begin
            cnt_d   = ONE_C;
            state_d = MEASURE;
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_q == TIMEOUT_C) state_d = LOST;
          end
        end
        MEASURE: begin
          // An edge arriving on the timeout cycle still counts as a period
          if (rise_c) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            cnt_d          = ONE_C;
            in_range_d     = per_ok_c & duty_ok_c;
            if (!(per_ok_c & duty_ok_c)) err_d = err_inc_c;
          end else if (cnt_q == TIMEOUT_C) begin
            lost_d  = 1'b1;
            err_d   = err_inc_c;
            state_d = LOST;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        LOST: begin
          if (rise_c) begin
            lost_d  = 1'b0;
            cnt_d   = ONE_C;
            state_d = MEASURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CLK_PERIOD_MONITOR_DUTY_EN
  localparam logic [CNT_W:0] NOM_HALF_C = (CNT_W+1)'(NOM_PERIOD / 2);

  logic [CNT_W-1:0] hi_cnt_q, hi_meas_q, high_time_q;

  // High phase length: cycles from synchronized rise to the following synchronized fall
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      hi_cnt_q    <= '0;
      hi_meas_q   <= '0;
      high_time_q <= '0;
    end else begin
      if (rise_c) hi_cnt_q <= ONE_C;
      else if (sync_out_c && (hi_cnt_q != TIMEOUT_C)) hi_cnt_q <= hi_cnt_q + ONE_C;
      if (fall_c) hi_meas_q <= hi_cnt_q;
      if (period_valid_d) high_time_q <= hi_meas_q;
    end
  end

  assign duty_ok_c = within_tol(hi_meas_q, NOM_HALF_C);
  assign high_time = high_time_q;
`else
  logic unused_fall_c;
  assign unused_fall_c = fall_c;
  assign duty_ok_c     = 1'b1;
`endif

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;
  assign lost         = lost_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor with NOM_PERIOD=20, TOL=2, TIMEOUT=50.
module tb_clk_period_monitor;

  localparam int CNT_W = 17;
  localparam int NOM   = 20;
  localparam int TOL   = 2;
  localparam int TMO   = 50;

  logic             clk_50Mhz = 1'b0;
  logic             rst, enable, clk_in;
  logic             tick, period_valid, in_range, lost;
  logic [CNT_W-1:0] period;
  logic [7:0]       err_count;
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
  logic [CNT_W-1:0] high_time;
`endif

  clk_period_monitor #(
    .SYNC_STAGES(2), .CNT_W(CNT_W), .NOM_PERIOD(NOM), .TOL(TOL), .TIMEOUT(TMO)
  ) dut (
    .clk_50Mhz   (clk_50Mhz),
    .rst         (rst),
    .enable      (enable),
    .clk_in      (clk_in),
    .tick        (tick),
    .period      (period),
    .period_valid(period_valid),
    .in_range    (in_range),
    .lost        (lost),
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
    .high_time   (high_time),
`endif
    .err_count   (err_count)
  );

  always #5 clk_50Mhz = ~clk_50Mhz;

  typedef struct packed {
    logic [CNT_W-1:0] p;
    logic             inr;
    logic [7:0]       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   model_err = 0;
  int   prev_len  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected report for a completed period of len cycles
  task automatic push_exp(input int len);
    exp_t e;
    bit   ok;
    ok = (len >= NOM - TOL) && (len <= NOM + TOL);
    if (!ok && model_err < 255) model_err++;
    e.p   = CNT_W'(len);
    e.inr = ok;
    e.err = 8'(model_err);
    sb_q.push_back(e);
  endtask

  // One clk_in period starting with a rise; report=1 when that rise closes a measured period
  task automatic period_step(input int hi, input int lo, input bit report);
    if (report) push_exp(prev_len);
    prev_len = hi + lo;
    clk_in = 1'b1;
    repeat (hi) @(posedge clk_50Mhz);
    #1;
    clk_in = 1'b0;
    repeat (lo) @(posedge clk_50Mhz);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"}, 32'(tick), 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_period_valid"}, 32'(period_valid), 0);
    check({tag, "_in_range"}, 32'(in_range), 0);
    check({tag, "_lost"}, 32'(lost), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  // Monitor: every period_valid pulse pops one expected report
  always @(negedge clk_50Mhz) begin
    if (!rst && period_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: period %0d reported, none expected (t=%0t)", period, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_period", 32'(period), 32'(mon_e.p));
        check("sb_in_range", 32'(in_range), 32'(mon_e.inr));
        check("sb_err_count", 32'(err_count), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; clk_in = 1'b0;
    repeat (2) @(posedge clk_50Mhz);
    #1;
    check_all_zero("reset");
    rst = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk_50Mhz);
    #1;

    // Nominal 20-cycle clock; first edge only acquires
    fork
      period_step(10, 10, 1'b0);
      begin
        repeat (2) @(posedge clk_50Mhz);
        @(negedge clk_50Mhz); check("tick_early", 32'(tick), 0);
        @(posedge clk_50Mhz);
        @(negedge clk_50Mhz); check("tick_latency", 32'(tick), 1);
      end
    join
    repeat (4) period_step(10, 10, 1'b1);

    // Out of range (24), then inclusive boundary (22)
    repeat (4) period_step(12, 12, 1'b1);
    repeat (3) period_step(11, 11, 1'b1);

    // Loss of clock: lost rises 50 clocks after the last tick
    push_exp(prev_len);
    clk_in = 1'b1;
    repeat (11) @(posedge clk_50Mhz);
    #1;
    clk_in = 1'b0;
    repeat (41) @(posedge clk_50Mhz);
    @(negedge clk_50Mhz); check("lost_before_timeout", 32'(lost), 0);
    @(posedge clk_50Mhz);
    @(negedge clk_50Mhz); check("lost_at_timeout", 32'(lost), 1);
    model_err++;
    check("lost_err_count", 32'(err_count), 32'(model_err));
    @(posedge clk_50Mhz);
    #1;
    period_step(10, 10, 1'b0);
    check("lost_clear", 32'(lost), 0);
    check("lost_err_hold", 32'(err_count), 32'(model_err));
    period_step(10, 10, 1'b1);

    // Enable dropped mid-period for 5 clocks
    push_exp(prev_len);
    clk_in = 1'b1;
    repeat (5) @(posedge clk_50Mhz);
    #1;
    enable = 1'b0;
    repeat (2) @(posedge clk_50Mhz);
    #1;
    check("disabled_period_hold", 32'(period), 20);
    check("disabled_in_range_hold", 32'(in_range), 1);
    repeat (3) @(posedge clk_50Mhz);
    #1;
    enable = 1'b1;
    clk_in = 1'b0;
    repeat (10) @(posedge clk_50Mhz);
    #1;
    period_step(10, 10, 1'b0);
    period_step(10, 10, 1'b1);
    check("err_before_reset", 32'(err_count), 32'(model_err));

    // One-cycle reset clears every output
    rst = 1'b1;
    @(posedge clk_50Mhz);
    #1;
    rst = 1'b0;
    check_all_zero("mid_reset");
    check("sb_empty_at_reset", 32'(sb_q.size()), 0);
    model_err = 0;

    // 300 out-of-range periods saturate err_count
    period_step(5, 5, 1'b0);
    repeat (300) period_step(5, 5, 1'b1);
    repeat (6) @(posedge clk_50Mhz);
    #1;
    check("err_saturated", 32'(err_count), 255);
    check("sb_drain", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
